// File: rtl/pipeline_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types for the pipeline stall/flush controller: controller state
// enum, the bundle of pipeline-register controls, the canned control
// patterns and the RUN-state priority decoder.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DMISS  = 3'd1,
    ST_IMISS  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Field order is MSB first: {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we}
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_ADVANCE = 6'b110011; // everything moves
  localparam pipe_ctrl_t CTRL_FREEZE  = 6'b000000; // nothing moves, nothing squashed
  localparam pipe_ctrl_t CTRL_BUBBLE  = 6'b000111; // hold PC+IF/ID, bubble into ID/EX
  localparam pipe_ctrl_t CTRL_IF_NOP  = 6'b011011; // hold PC, NOP into IF/ID, back end moves
  localparam pipe_ctrl_t CTRL_BRANCH  = 6'b111011; // redirect PC, squash fall-through

  // RUN-state control with the data-miss case already excluded by the caller.
  // A pending hazard hides the branch decision (its operands are not ready).
  function automatic pipe_ctrl_t run_ctrl(input logic hazard, input logic imiss,
                                          input logic halt, input logic branch);
    if (hazard)             return CTRL_BUBBLE;
    else if (imiss || halt) return CTRL_IF_NOP;
    else if (branch)        return CTRL_BRANCH;
    else                    return CTRL_ADVANCE;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
// Bundles hazard/cache/halt requests into the controller and the pipeline
// enables, flushes, status flags and perf counters out of it.
//   master : hazard unit / caches / pipeline side (drives requests)
//   slave  : pipeline_stall_ctrl (drives enables, flushes, status)
// ---------------------------------------------------------------------------
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hazard_stall;
  logic             branch_taken;
  logic             icache_miss;
  logic             icache_ready;
  logic             dcache_miss;
  logic             dcache_ready;
  logic             halt_id;
  logic             halt_wb;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_we;
  logic             mem_wb_we;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hazard_stall, branch_taken, icache_miss, icache_ready,
           dcache_miss, dcache_ready, halt_id, halt_wb,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
           halted, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard_stall, branch_taken, icache_miss, icache_ready,
           dcache_miss, dcache_ready, halt_id, halt_wb,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we,
           halted, err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: increments on i_inc, sticks at all-ones.
//   i_clk  clock (rising edge)
//   i_rst  synchronous active-high clear
//   i_inc  count enable
//   o_cnt  current count
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)                     r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Consumer side of the hazard/stall protocol. Turns hazard stalls, ID branch
// decisions, I/D cache miss handshakes and HLT tracking into write enables
// and flushes for the PC and all pipeline registers. Enables/flushes are
// combinational from state + inputs; flags and counters are registered.
//   i_clk   clock (rising edge)
//   i_rst   synchronous active-high reset
//   io_bus  pipeline_stall_ctrl_if.slave: requests in; pc/if_id/ex_mem/mem_wb
//           write enables, if_id/id_ex flushes, halted, err (sticky miss
//           timeout), stall_cnt and flush_cnt (saturating) out
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pipeline_stall_ctrl_if.slave  io_bus
);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT);

  state_e           r_state;
  state_e           w_next;
  pipe_ctrl_t       w_ctrl;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_err;
  logic             w_in_miss;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  // Next state and Mealy controls
  always_comb begin
    w_ctrl = CTRL_ADVANCE;
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (io_bus.dcache_miss) begin
          w_ctrl = CTRL_FREEZE;
          w_next = ST_DMISS;
        end else begin
          w_ctrl = run_ctrl(io_bus.hazard_stall, io_bus.icache_miss,
                            io_bus.halt_id, io_bus.branch_taken);
          // A stall cycle only bubbles; the fetch miss / HLT is taken next cycle
          if (!io_bus.hazard_stall) begin
            if (io_bus.icache_miss)  w_next = ST_IMISS;
            else if (io_bus.halt_id) w_next = ST_DRAIN;
          end
        end
      end
      ST_DMISS: begin
        // Ready wins over a still-asserted dcache_miss: the exit cycle runs
        // normal RUN rules and a re-asserted miss is picked up from RUN.
        if (io_bus.dcache_ready) begin
          w_ctrl = run_ctrl(io_bus.hazard_stall, io_bus.icache_miss,
                            io_bus.halt_id, io_bus.branch_taken);
          w_next = io_bus.icache_miss ? ST_IMISS : ST_RUN;
        end else begin
          w_ctrl = CTRL_FREEZE;
        end
      end
      ST_IMISS: begin
        // Data miss preempts; icache_miss stays high and is resumed from DMISS
        if (io_bus.dcache_miss) begin
          w_ctrl = CTRL_FREEZE;
          w_next = ST_DMISS;
        end else begin
          w_ctrl = CTRL_IF_NOP;
          if (io_bus.icache_ready) w_next = ST_RUN;
        end
      end
      ST_DRAIN: begin
        w_ctrl = CTRL_IF_NOP;
        if (io_bus.halt_wb) w_next = ST_HALTED;
      end
      ST_HALTED: w_ctrl = CTRL_FREEZE;
      default: begin
        w_ctrl = CTRL_FREEZE;
        w_next = ST_RUN;
      end
    endcase
  end

  assign w_in_miss = (r_state == ST_DMISS) || (r_state == ST_IMISS);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_RUN;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counts miss-state cycles already elapsed in the current miss stretch
      if (!w_in_miss)           r_to_cnt <= '0;
      else if (r_to_cnt != '1)  r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_in_miss && (TO_LIM != 32'd0) && (32'(r_to_cnt) == TO_LIM))
        r_err <= 1'b1;
    end
  end

  assign w_stall_inc = !w_ctrl.pc_we && (r_state != ST_HALTED);
  assign w_flush_inc = w_ctrl.if_id_flush || w_ctrl.id_ex_flush;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_stall_inc),
    .o_cnt (w_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_flush_inc),
    .o_cnt (w_flush_cnt)
  );

  assign io_bus.pc_we       = w_ctrl.pc_we;
  assign io_bus.if_id_we    = w_ctrl.if_id_we;
  assign io_bus.if_id_flush = w_ctrl.if_id_flush;
  assign io_bus.id_ex_flush = w_ctrl.id_ex_flush;
  assign io_bus.ex_mem_we   = w_ctrl.ex_mem_we;
  assign io_bus.mem_wb_we   = w_ctrl.mem_wb_we;
  assign io_bus.halted      = (r_state == ST_HALTED);
  assign io_bus.err         = r_err;
  assign io_bus.stall_cnt   = w_stall_cnt;
  assign io_bus.flush_cnt   = w_flush_cnt;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
// Directed bench for pipeline_stall_ctrl. A protocol-level model predicts
// every output each cycle; directed scenarios add hand-computed literals.
// Inputs change 1 time unit after the rising edge; checks run on the
// falling edge (model) or after settling (literals).
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 200;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- protocol model ----------------
  typedef enum {M_RUN, M_DWAIT, M_IWAIT, M_DRAIN, M_STOP} mode_e;
  mode_e m_mode  = M_RUN;
  int    m_stall = 0;
  int    m_flush = 0;
  int    m_age   = 0;   // consecutive miss cycles including the current one
  bit    m_err   = 0;

  // Control patterns {pc, if_id_we, if_id_flush, id_ex_flush, ex_mem, mem_wb}
  function automatic logic [5:0] run_rule(input logic h, input logic ic,
                                          input logic hl, input logic br);
    if (h)        return 6'b000111;
    if (ic || hl) return 6'b011011;
    if (br)       return 6'b111011;
    return 6'b110011;
  endfunction

  always @(negedge clk) begin
    logic [5:0] e;
    mode_e nx;
    e  = 6'b110011;
    nx = m_mode;
    case (m_mode)
      M_RUN:
        if (bus.dcache_miss) begin e = 6'b0; nx = M_DWAIT; end
        else begin
          e = run_rule(bus.hazard_stall, bus.icache_miss, bus.halt_id, bus.branch_taken);
          if (!bus.hazard_stall)
            nx = bus.icache_miss ? M_IWAIT : (bus.halt_id ? M_DRAIN : M_RUN);
        end
      M_DWAIT:
        if (bus.dcache_ready) begin
          e  = run_rule(bus.hazard_stall, bus.icache_miss, bus.halt_id, bus.branch_taken);
          nx = bus.icache_miss ? M_IWAIT : M_RUN;
        end else e = 6'b0;
      M_IWAIT:
        if (bus.dcache_miss) begin e = 6'b0; nx = M_DWAIT; end
        else begin e = 6'b011011; if (bus.icache_ready) nx = M_RUN; end
      M_DRAIN: begin e = 6'b011011; if (bus.halt_wb) nx = M_STOP; end
      default: e = 6'b0;
    endcase
    chk("pc_we",       bus.pc_we,       e[5]);
    chk("if_id_we",    bus.if_id_we,    e[4]);
    chk("if_id_flush", bus.if_id_flush, e[3]);
    chk("id_ex_flush", bus.id_ex_flush, e[2]);
    chk("ex_mem_we",   bus.ex_mem_we,   e[1]);
    chk("mem_wb_we",   bus.mem_wb_we,   e[0]);
    chk("halted",      bus.halted,      m_mode == M_STOP);
    chk("err",         bus.err,         m_err);
    chk("stall_cnt",   bus.stall_cnt,   m_stall);
    chk("flush_cnt",   bus.flush_cnt,   m_flush);
    if (rst) begin
      m_mode = M_RUN; m_stall = 0; m_flush = 0; m_age = 0; m_err = 0;
    end else begin
      if (!e[5] && m_mode != M_STOP && m_stall < SAT) m_stall++;
      if ((e[3] || e[2]) && m_flush < SAT) m_flush++;
      if (m_mode == M_DWAIT || m_mode == M_IWAIT) m_age++;
      else m_age = 0;
      if (TIMEOUT != 0 && m_age > TIMEOUT) m_err = 1;
      m_mode = nx;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.hazard_stall = 0; bus.branch_taken = 0; bus.icache_miss = 0; bus.icache_ready = 0;
    bus.dcache_miss  = 0; bus.dcache_ready = 0; bus.halt_id     = 0; bus.halt_wb      = 0;
  endtask

  task automatic do_reset();
    rst = 1; clr_in(); step(2); rst = 0; #1;
  endtask

  initial begin
    clr_in();
    step(2); rst = 0;

    // Idle after reset
    step(10);
    chk("idle pc_we", bus.pc_we, 1);
    chk("idle if_id_flush", bus.if_id_flush, 0);
    chk("idle stall_cnt", bus.stall_cnt, 0);
    chk("idle halted", bus.halted, 0);

    // Hazard hides branch
    bus.hazard_stall = 1; bus.branch_taken = 1; #1;
    chk("hz pc_we", bus.pc_we, 0);
    chk("hz if_id_we", bus.if_id_we, 0);
    chk("hz id_ex_flush", bus.id_ex_flush, 1);
    chk("hz if_id_flush", bus.if_id_flush, 0);
    step(1); clr_in(); #1;
    chk("hz stall_cnt", bus.stall_cnt, 1);
    chk("hz flush_cnt", bus.flush_cnt, 1);

    // Branch alone squashes the fall-through
    bus.branch_taken = 1; #1;
    chk("br pc_we", bus.pc_we, 1);
    chk("br if_id_flush", bus.if_id_flush, 1);
    step(1); clr_in();

    // Data miss at cycle 5, ready at cycle 9
    do_reset();
    step(4);
    bus.dcache_miss = 1; step(2);
    chk("dm freeze pc_we", bus.pc_we, 0);
    chk("dm freeze ex_mem_we", bus.ex_mem_we, 0);
    step(2);
    bus.dcache_miss = 0; bus.dcache_ready = 1; #1;
    chk("dm exit pc_we", bus.pc_we, 1);
    chk("dm exit mem_wb_we", bus.mem_wb_we, 1);
    step(1); clr_in(); #1;
    chk("dm stall_cnt", bus.stall_cnt, 4);

    // Data+fetch miss together, data served first
    do_reset();
    bus.dcache_miss = 1; bus.icache_miss = 1; step(3);
    bus.dcache_miss = 0; bus.dcache_ready = 1; step(1);
    bus.dcache_ready = 0; #1;
    chk("di imiss if_id_flush", bus.if_id_flush, 1);
    chk("di imiss pc_we", bus.pc_we, 0);
    step(2);
    bus.icache_miss = 0; bus.icache_ready = 1; step(1);
    bus.icache_ready = 0; #1;
    chk("di run pc_we", bus.pc_we, 1);
    chk("di run if_id_flush", bus.if_id_flush, 0);
    chk("di stall_cnt", bus.stall_cnt, 7);
    chk("di flush_cnt", bus.flush_cnt, 4);

    // Fetch miss preempted by a data miss; ready with miss still high
    do_reset();
    bus.icache_miss = 1; step(2);
    bus.dcache_miss = 1; step(2);
    bus.dcache_ready = 1; step(1);
    bus.dcache_ready = 0; bus.dcache_miss = 0; step(2);
    bus.icache_miss = 0; bus.icache_ready = 1; step(1);
    clr_in(); step(2);

    // Timeout: miss held 250 cycles
    do_reset();
    bus.dcache_miss = 1; step(150);
    chk("to early err", bus.err, 0);
    step(100);
    chk("to late err", bus.err, 1);
    bus.dcache_miss = 0; bus.dcache_ready = 1; step(1);
    bus.dcache_ready = 0; #1;
    chk("to stall_cnt", bus.stall_cnt, 250);
    // Counter saturation: 10 more frozen cycles
    bus.dcache_miss = 1; step(10);
    bus.dcache_miss = 0; bus.dcache_ready = 1; step(1);
    bus.dcache_ready = 0; step(3);
    chk("sat stall_cnt", bus.stall_cnt, 255);
    chk("sticky err", bus.err, 1);

    // Reset in the middle of a miss
    do_reset();
    chk("rst clears err", bus.err, 0);
    bus.dcache_miss = 1; step(3);
    rst = 1; bus.dcache_miss = 0; step(1); rst = 0; #1;
    chk("rst mid pc_we", bus.pc_we, 1);
    chk("rst mid stall_cnt", bus.stall_cnt, 0);

    // Halt: HLT in ID, drain, HLT reaches WB
    do_reset();
    bus.halt_id = 1; step(1);
    bus.halt_id = 0; step(1);
    bus.halt_wb = 1; step(1);
    bus.halt_wb = 0; #1;
    chk("hlt halted", bus.halted, 1);
    chk("hlt pc_we", bus.pc_we, 0);
    chk("hlt mem_wb_we", bus.mem_wb_we, 0);
    chk("hlt flush_cnt", bus.flush_cnt, 3);
    bus.hazard_stall = 1; bus.branch_taken = 1; bus.icache_miss = 1; step(5);
    chk("hlt stall frozen", bus.stall_cnt, 3);
    chk("hlt still halted", bus.halted, 1);
    rst = 1; clr_in(); step(1); rst = 0; #1;
    chk("hlt rst halted", bus.halted, 0);
    chk("hlt rst pc_we", bus.pc_we, 1);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
